// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute block: opcodes, FSM state encoding,
// flag bit positions and small opcode classification helpers.
package alu_pkg;

  localparam int unsigned OpWidth   = 4;
  localparam int unsigned FlagWidth = 4;

  // Bit positions inside the Flags vector
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [OpWidth-1:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ROR  = 4'd10,
    OP_MULL = 4'd11,
    OP_MULH = 4'd12,
    OP_CMP  = 4'd13,
    OP_MOV  = 4'd14,
    OP_RSVD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } alu_state_e;

  // Multiply opcodes take the multi-cycle path
  function automatic logic op_is_mul(input alu_op_e op);
    return (op == OP_MULL) || (op == OP_MULH);
  endfunction

  // Opcodes that write their result back to the register file
  function automatic logic op_writes(input alu_op_e op);
    return !((op == OP_CMP) || (op == OP_RSVD));
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (sync, active low), start (loads a/b and processes bit 0),
//        a, b (operands), done (one-cycle pulse once product is complete),
//        product (2*DataWidth-bit result, held until the next start).
module alu_mul_seq #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DataWidth-1:0]     a,
  input  logic [DataWidth-1:0]     b,
  output logic                     done,
  output logic [2*DataWidth-1:0]   product
);

  localparam int unsigned ProdWidth = 2 * DataWidth;
  localparam int unsigned CntWidth  = $clog2(DataWidth + 1);

  logic [ProdWidth-1:0] mcand;
  logic [DataWidth-1:0] mult;
  logic [CntWidth-1:0]  cnt;
  logic                 run;

  // Bit 0 is consumed on the start edge, the remaining bits on the following
  // DataWidth-1 edges, so done is visible during the DataWidth-th cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mult    <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? ProdWidth'(a) : '0;
        mcand   <= ProdWidth'(a) << 1;
        mult    <= b >> 1;
        cnt     <= CntWidth'(DataWidth - 1);
        run     <= 1'b1;
      end else if (run) begin
        if (mult[0]) begin
          product <= product + mcand;
        end
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt - CntWidth'(1);
        if (cnt == CntWidth'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: latches an operation in IDLE, computes it (single cycle
// or sequential multiply), then spends one write-back cycle driving the
// register file.
// Ports: Clk, Reset_N (sync, active low), Start/Op/SrcA/SrcB/DstSel (request),
//        Result/REG_Dst/REG_WE (write-back, REG_WE active low),
//        Flags ({V,N,Z,C}), Busy (not IDLE), Done (write-back pulse).
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned SelectSize = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  Start,
  input  logic [OpWidth-1:0]    Op,
  input  logic [DataWidth-1:0]  SrcA,
  input  logic [DataWidth-1:0]  SrcB,
  input  logic [SelectSize-1:0] DstSel,
  output logic [DataWidth-1:0]  Result,
  output logic [SelectSize-1:0] REG_Dst,
  output logic                  REG_WE,
  output logic [FlagWidth-1:0]  Flags,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned W   = DataWidth;
  localparam int unsigned WP1 = DataWidth + 1;

  alu_state_e           state;
  alu_op_e              op_q;
  alu_op_e              op_in_c;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic                 mul_start_c;
  logic                 mul_done;
  logic [2*W-1:0]       mul_product;
  logic                 cin_c;
  logic [W:0]           sum_c;
  logic [W:0]           diff_c;
  logic [W-1:0]         res_c;
  logic                 c_c;
  logic                 v_c;
  logic [FlagWidth-1:0] flags_c;

  assign op_in_c     = alu_op_e'(Op);
  assign mul_start_c = (state == ST_IDLE) && Start && op_is_mul(op_in_c);

  alu_mul_seq #(
    .DataWidth(DataWidth)
  ) u_mul (
    .clk    (Clk),
    .rst_n  (Reset_N),
    .start  (mul_start_c),
    .a      (SrcA),
    .b      (SrcB),
    .done   (mul_done),
    .product(mul_product)
  );

  // Carry-in comes from the flags held before the op; diff_c[W] is the borrow
  assign cin_c  = Flags[FLAG_C];
  assign sum_c  = {1'b0, a_q} + {1'b0, b_q} + WP1'((op_q == OP_ADC) ? cin_c : 1'b0);
  assign diff_c = {1'b0, a_q} - {1'b0, b_q} - WP1'((op_q == OP_SBC) ? cin_c : 1'b0);

  // Result and flag generation for the latched operation
  always_comb begin
    res_c   = Result;
    c_c     = 1'b0;
    v_c     = 1'b0;
    flags_c = '0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        res_c = sum_c[W-1:0];
        c_c   = sum_c[W];
        v_c   = (a_q[W-1] == b_q[W-1]) && (sum_c[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res_c = diff_c[W-1:0];
        c_c   = diff_c[W];
        v_c   = (a_q[W-1] != b_q[W-1]) && (diff_c[W-1] != a_q[W-1]);
      end
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_XOR:  res_c = a_q ^ b_q;
      OP_NOT:  res_c = ~a_q;
      OP_MOV:  res_c = b_q;
      OP_SHL: begin
        res_c = {a_q[W-2:0], 1'b0};
        c_c   = a_q[W-1];
      end
      OP_SHR: begin
        res_c = {1'b0, a_q[W-1:1]};
        c_c   = a_q[0];
      end
      OP_ROR: begin
        res_c = {cin_c, a_q[W-1:1]};
        c_c   = a_q[0];
      end
      OP_MULL: begin
        res_c = mul_product[W-1:0];
        c_c   = |mul_product[2*W-1:W];
      end
      OP_MULH: begin
        res_c = mul_product[2*W-1:W];
        c_c   = |mul_product[2*W-1:W];
      end
      default: ;
    endcase
    flags_c[FLAG_C] = c_c;
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_N] = res_c[W-1];
    flags_c[FLAG_V] = v_c;
  end

  // Control FSM with registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      Result  <= '0;
      Flags   <= '0;
      REG_Dst <= '0;
      REG_WE  <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done   <= 1'b0;
          REG_WE <= 1'b1;
          if (Start) begin
            a_q     <= SrcA;
            b_q     <= SrcB;
            op_q    <= op_in_c;
            REG_Dst <= DstSel;
            Busy    <= 1'b1;
            state   <= op_is_mul(op_in_c) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q != OP_RSVD) begin
            Flags <= flags_c;
          end
          if (op_writes(op_q)) begin
            Result <= res_c;
          end
          REG_WE <= !op_writes(op_q);
          Done   <= 1'b1;
          state  <= ST_WB;
        end
        ST_MUL: begin
          if (mul_done) begin
            Result <= res_c;
            Flags  <= flags_c;
            REG_WE <= 1'b0;
            Done   <= 1'b1;
            state  <= ST_WB;
          end
        end
        ST_WB: begin
          REG_WE <= 1'b1;
          Done   <= 1'b0;
          Busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [3:0]    op;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [SS-1:0] dst_sel;
  logic [DW-1:0] result;
  logic [SS-1:0] reg_dst;
  logic          reg_we;
  logic [3:0]    flags;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] obs_result;
  logic [3:0]    obs_flags;
  logic [SS-1:0] obs_dst;
  logic          obs_we;
  int            obs_we_low;
  int            obs_done;
  int            obs_busy;
  logic          obs_finished;

  always #5 clk = ~clk;

  alu_exec #(
    .DataWidth (DW),
    .SelectSize(SS)
  ) dut (
    .Clk    (clk),
    .Reset_N(reset_n),
    .Start  (start),
    .Op     (op),
    .SrcA   (src_a),
    .SrcB   (src_b),
    .DstSel (dst_sel),
    .Result (result),
    .REG_Dst(reg_dst),
    .REG_WE (reg_we),
    .Flags  (flags),
    .Busy   (busy),
    .Done   (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, optionally pulse Start at loop index pulse_at, observe until idle
  task automatic run_op(input alu_op_e o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [SS-1:0] d, input int pulse_at);
    logic seen_done;
    seen_done    = 1'b0;
    obs_finished = 1'b0;
    obs_we_low   = 0;
    obs_done     = 0;
    obs_busy     = 0;
    obs_we       = 1'b1;
    obs_result   = '0;
    obs_flags    = '0;
    obs_dst      = '0;
    op = o; src_a = a; src_b = b; dst_sel = d; start = 1'b1;
    tick();
    start = 1'b0; op = OP_ADD; src_a = '0; src_b = '0; dst_sel = '0;
    for (int i = 0; i < 40 && !obs_finished; i++) begin
      if (busy) obs_busy++;
      if (!reg_we) obs_we_low++;
      if (done) begin
        obs_done++;
        seen_done  = 1'b1;
        obs_result = result;
        obs_flags  = flags;
        obs_dst    = reg_dst;
        obs_we     = reg_we;
      end
      if (seen_done && !busy) obs_finished = 1'b1;
      else begin
        start = (i == pulse_at);
        op    = OP_ADD;
        tick();
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) obs_busy++;
      if (!reg_we) obs_we_low++;
      if (done) obs_done++;
    end
  endtask

  task automatic op_check(input string name, input alu_op_e o, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [SS-1:0] d, input int pulse_at,
                          input logic [DW-1:0] exp_r, input logic [3:0] exp_f,
                          input int exp_we_low, input int exp_busy);
    run_op(o, a, b, d, pulse_at);
    check({name, ".finish"}, 32'(obs_finished), 32'(1));
    check({name, ".result"}, 32'(obs_result), 32'(exp_r));
    check({name, ".flags"},  32'(obs_flags),  32'(exp_f));
    check({name, ".dst"},    32'(obs_dst),    32'(d));
    check({name, ".we_wb"},  32'(obs_we),     32'(exp_we_low == 0));
    check({name, ".we_cnt"}, 32'(obs_we_low), 32'(exp_we_low));
    check({name, ".done"},   32'(obs_done),   32'(1));
    check({name, ".busy"},   32'(obs_busy),   32'(exp_busy));
  endtask

  initial begin
    int we_low;
    int dn;
    reset_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst_sel = '0;
    tick(); tick();
    check("rst.result", 32'(result),  32'(0));
    check("rst.flags",  32'(flags),   32'(0));
    check("rst.we",     32'(reg_we),  32'(1));
    check("rst.busy",   32'(busy),    32'(0));
    check("rst.done",   32'(done),    32'(0));
    check("rst.dst",    32'(reg_dst), 32'(0));
    reset_n = 1'b1;
    tick();

    // Flags column is {V,N,Z,C}
    op_check("add",  OP_ADD,  8'h7F, 8'h01, 3'd3, -1, 8'h80, 4'hC, 1, 2);
    op_check("sub",  OP_SUB,  8'h10, 8'h20, 3'd1, -1, 8'hF0, 4'h5, 1, 2);
    op_check("sbc",  OP_SBC,  8'h05, 8'h01, 3'd2, -1, 8'h03, 4'h0, 1, 2);
    op_check("mull", OP_MULL, 8'h0F, 8'h11, 3'd4, -1, 8'hFF, 4'h4, 1, 9);
    op_check("mulh", OP_MULH, 8'h10, 8'h10, 3'd5, -1, 8'h01, 4'h1, 1, 9);
    op_check("cmp",  OP_CMP,  8'h42, 8'h42, 3'd6, -1, 8'h01, 4'h2, 0, 2);
    op_check("shr",  OP_SHR,  8'h01, 8'h00, 3'd7, -1, 8'h00, 4'h3, 1, 2);
    op_check("adc",  OP_ADC,  8'hFF, 8'h00, 3'd0, -1, 8'h00, 4'h3, 1, 2);
    op_check("ror",  OP_ROR,  8'h02, 8'h00, 3'd1, -1, 8'h81, 4'h4, 1, 2);
    op_check("rsvd", OP_RSVD, 8'h55, 8'hAA, 3'd2, -1, 8'h81, 4'h4, 0, 2);
    op_check("mov",  OP_MOV,  8'hFF, 8'h00, 3'd3, -1, 8'h00, 4'h2, 1, 2);
    op_check("shl",  OP_SHL,  8'h81, 8'h00, 3'd4, -1, 8'h02, 4'h1, 1, 2);
    op_check("xor",  OP_XOR,  8'hF0, 8'hFF, 3'd5, -1, 8'h0F, 4'h0, 1, 2);
    op_check("subv", OP_SUB,  8'h80, 8'h01, 3'd6, -1, 8'h7F, 4'h8, 1, 2);
    op_check("mul_pulse", OP_MULL, 8'h03, 8'h05, 3'd7, 2, 8'h0F, 4'h0, 1, 9);
    op_check("not_wb_pulse", OP_NOT, 8'h0F, 8'h00, 3'd1, 1, 8'hF0, 4'h4, 1, 2);
    op_check("and",  OP_AND,  8'hA5, 8'h0F, 3'd2, -1, 8'h05, 4'h0, 1, 2);
    op_check("or",   OP_OR,   8'h00, 8'h00, 3'd3, -1, 8'h00, 4'h2, 1, 2);

    // Reset on the 4th multiply cycle aborts without a write
    we_low = 0;
    dn     = 0;
    op = OP_MULL; src_a = 8'hFF; src_b = 8'hFF; dst_sel = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!reg_we) we_low++;
      if (done) dn++;
      tick();
    end
    check("abort.busy_before", 32'(busy), 32'(1));
    reset_n = 1'b0;
    tick();
    check("abort.flags",  32'(flags),   32'(0));
    check("abort.busy",   32'(busy),    32'(0));
    check("abort.result", 32'(result),  32'(0));
    check("abort.dst",    32'(reg_dst), 32'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!reg_we) we_low++;
      if (done) dn++;
      tick();
    end
    check("abort.we_low", 32'(we_low), 32'(0));
    check("abort.done",   32'(dn),     32'(0));

    op_check("recover", OP_ADD, 8'h01, 8'h01, 3'd2, -1, 8'h02, 4'h0, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
